// File: rtl/vec_cordic_angle_gen.sv
// Pipelined vectoring-mode CORDIC. It emits the direction word and the K-scaled magnitude, and has 4 register stages.
// Optional build macro VEC_ANGLE_ROUND_EN: round-half-up on the X_o scaling (default truncates).
module vec_cordic_angle_gen #(
  parameter int BITWIDTH   = 18,
  parameter int CORDIC_NUM = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic signed [BITWIDTH-1:0] X_i,
  input  logic signed [BITWIDTH-1:0] Y_i,
  output logic                       valid_o,
  output logic [CORDIC_NUM-1:0]      d_o,
  output logic signed [BITWIDTH-1:0] X_o,
  output logic signed [BITWIDTH-1:0] Y_o
);
  localparam int PIPE_NUM = 4;
  localparam int W        = BITWIDTH + 2;
  localparam int PW       = BITWIDTH + 17;
  localparam int S1_K     = 4;
  localparam int S2_K     = 9;
  localparam logic signed [14:0] K_SCALE = 15'b010011011011101;

  logic [PIPE_NUM-1:0]        vld_q;
  logic signed [W-1:0]        x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
  logic [S1_K-1:0]            d0_q;
  logic [S2_K-1:0]            d1_q;
  logic [CORDIC_NUM-1:0]      d2_q, do_q;
  logic signed [BITWIDTH-1:0] xo_q, yo_q;
  logic [CORDIC_NUM-1:0]      dc;
  logic signed [W-1:0]        x_in, y_in;
  logic signed [PW-1:0]       prod, prod_adj;

  assign x_in = {{2{X_i[BITWIDTH-1]}}, X_i};
  assign y_in = {{2{Y_i[BITWIDTH-1]}}, Y_i};

  // One micro-rotation per iteration; stage boundaries re-source from the registers.
  genvar k;
  for (k = 0; k < CORDIC_NUM; k++) begin : g_it
    logic signed [W-1:0] xa, ya, xn, yn;
    if (k == 0) begin : g_src
      assign xa = x_in;
      assign ya = y_in;
    end else if (k == S1_K) begin : g_src
      assign xa = x0_q;
      assign ya = y0_q;
    end else if (k == S2_K) begin : g_src
      assign xa = x1_q;
      assign ya = y1_q;
    end else begin : g_src
      assign xa = g_it[k-1].xn;
      assign ya = g_it[k-1].yn;
    end
    assign dc[k] = ya[W-1];
    assign xn = ya[W-1] ? xa - (ya >>> k) : xa + (ya >>> k);
    assign yn = ya[W-1] ? ya + (xa >>> k) : ya - (xa >>> k);
  end

  assign prod = PW'(x2_q) * PW'(K_SCALE);
`ifdef VEC_ANGLE_ROUND_EN
  assign prod_adj = prod + PW'(8192);
`else
  assign prod_adj = prod;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      x0_q  <= '0;  y0_q <= '0;  d0_q <= '0;
      x1_q  <= '0;  y1_q <= '0;  d1_q <= '0;
      x2_q  <= '0;  y2_q <= '0;  d2_q <= '0;
      xo_q  <= '0;  yo_q <= '0;  do_q <= '0;
    end else begin
      vld_q <= {vld_q[PIPE_NUM-2:0], valid_i};
      if (valid_i) begin
        x0_q <= g_it[S1_K-1].xn;
        y0_q <= g_it[S1_K-1].yn;
        d0_q <= dc[S1_K-1:0];
      end
      if (vld_q[0]) begin
        x1_q <= g_it[S2_K-1].xn;
        y1_q <= g_it[S2_K-1].yn;
        d1_q <= {dc[S2_K-1:S1_K], d0_q};
      end
      if (vld_q[1]) begin
        x2_q <= g_it[CORDIC_NUM-1].xn;
        y2_q <= g_it[CORDIC_NUM-1].yn;
        d2_q <= {dc[CORDIC_NUM-1:S2_K], d1_q};
      end
      if (vld_q[2]) begin
        xo_q <= BITWIDTH'(prod_adj >>> 14);
        yo_q <= BITWIDTH'(y2_q);
        do_q <= d2_q;
      end
    end
  end

  assign valid_o = vld_q[PIPE_NUM-1];
  assign d_o     = do_q;
  assign X_o     = xo_q;
  assign Y_o     = yo_q;
endmodule

// File: tb/tb_vec_cordic_angle_gen.sv
// Directed bench for vec_cordic_angle_gen: reset, known vectors, streaming with bubbles, rounding boundary.
module tb_vec_cordic_angle_gen;
  logic               clk = 0, rst_n = 0, valid_i = 0;
  logic signed [17:0] X_i = '0, Y_i = '0;
  logic               valid_o;
  logic [13:0]        d_o;
  logic signed [17:0] X_o, Y_o;
  int tests = 0, fails = 0;

  vec_cordic_angle_gen dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .X_i(X_i), .Y_i(Y_i),
    .valid_o(valid_o), .d_o(d_o), .X_o(X_o), .Y_o(Y_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic void model(input int xi, input int yi, output int xs, output int ys,
                                output logic [13:0] d);
    int x, y, xt;
    x = xi; y = yi; d = '0;
    for (int k = 0; k < 14; k++) begin
      if (y < 0) begin
        d[k] = 1'b1; xt = x - (y >>> k); y = y + (x >>> k);
      end else begin
        xt = x + (y >>> k); y = y - (x >>> k);
      end
      x = xt;
    end
    xs = x; ys = y;
  endfunction

  function automatic logic signed [17:0] scale(input int xs, input bit rnd);
    longint p;
    p = longint'(xs) * 64'sd9949;
    if (rnd) p = p + 64'sd8192;
    p = p >>> 14;
    return 18'(p);
  endfunction

  function automatic logic signed [17:0] exp_x(input int xs);
`ifdef VEC_ANGLE_ROUND_EN
    return scale(xs, 1'b1);
`else
    return scale(xs, 1'b0);
`endif
  endfunction

  task automatic pulse(input int xi, input int yi, output int lat, output logic [13:0] d,
                       output logic signed [17:0] xo, output logic signed [17:0] yo);
    valid_i = 1; X_i = 18'(xi); Y_i = 18'(yi);
    step();
    valid_i = 0; X_i = 18'sd777; Y_i = -18'sd555;
    lat = 1;
    while (valid_o !== 1'b1 && lat < 10) begin step(); lat++; end
    d = d_o; xo = X_o; yo = Y_o;
    step();
  endtask

  task automatic test_reset();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b want 0", valid_o); end
    tests++; if (d_o !== 14'd0) begin fails++; $display("FAIL rst_d got %h want 0", d_o); end
    tests++; if (X_o !== 18'sd0) begin fails++; $display("FAIL rst_x got %0d want 0", X_o); end
    tests++; if (Y_o !== 18'sd0) begin fails++; $display("FAIL rst_y got %0d want 0", Y_o); end
    step(); rst_n = 1; step();
    for (int i = 0; i < 6; i++) begin
      valid_i = 1; X_i = 18'(3000 + 100 * i); Y_i = 18'(1500 - 700 * i);
      step();
    end
    rst_n = 0; #1;
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL midrst_valid got %0b want 0", valid_o); end
    tests++; if (d_o !== 14'd0) begin fails++; $display("FAIL midrst_d got %h want 0", d_o); end
    tests++; if (X_o !== 18'sd0) begin fails++; $display("FAIL midrst_x got %0d want 0", X_o); end
    tests++; if (Y_o !== 18'sd0) begin fails++; $display("FAIL midrst_y got %0d want 0", Y_o); end
    step(); valid_i = 0; step(); rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (valid_o !== 1'b0) begin fails++; $display("FAIL stale_valid cyc %0d got %0b want 0", i, valid_o); end
    end
  endtask

  task automatic test_mag_3_4();
    int lat, xs, ys, xv, yv; logic [13:0] d, md; logic signed [17:0] xo, yo;
    pulse(3000, 4000, lat, d, xo, yo);
    model(3000, 4000, xs, ys, md);
    xv = xo; yv = yo;
    tests++; if (lat !== 4) begin fails++; $display("FAIL m34_latency got %0d want 4", lat); end
    tests++; if (xv < 4997 || xv > 5003) begin fails++; $display("FAIL m34_mag got %0d want 5000+-3", xv); end
    tests++; if (yv < -2 || yv > 2) begin fails++; $display("FAIL m34_resid got %0d want |y|<=2", yv); end
    tests++; if (d[0] !== 1'b0) begin fails++; $display("FAIL m34_d0 got %0b want 0", d[0]); end
    tests++; if (d !== md) begin fails++; $display("FAIL m34_d got %h want %h", d, md); end
    tests++; if (xo !== exp_x(xs)) begin fails++; $display("FAIL m34_x got %0d want %0d", xo, exp_x(xs)); end
    tests++; if (yo !== 18'(ys)) begin fails++; $display("FAIL m34_y got %0d want %0d", yo, ys); end
  endtask

  task automatic test_zero_y();
    int lat, xs, ys, xv, yv; logic [13:0] d, md; logic signed [17:0] xo, yo;
    pulse(1000, 0, lat, d, xo, yo);
    model(1000, 0, xs, ys, md);
    xv = xo; yv = yo;
    tests++; if (lat !== 4) begin fails++; $display("FAIL zy_latency got %0d want 4", lat); end
    tests++; if (xv < 998 || xv > 1002) begin fails++; $display("FAIL zy_mag got %0d want 1000+-2", xv); end
    tests++; if (yv < -1 || yv > 1) begin fails++; $display("FAIL zy_resid got %0d want |y|<=1", yv); end
    tests++; if (d[1:0] !== 2'b10) begin fails++; $display("FAIL zy_d10 got %b want 10", d[1:0]); end
    tests++; if (d !== md) begin fails++; $display("FAIL zy_d got %h want %h", d, md); end
    tests++; if (xo !== exp_x(xs)) begin fails++; $display("FAIL zy_x got %0d want %0d", xo, exp_x(xs)); end
  endtask

  task automatic test_diag();
    int lat, xs, ys, xv, x, y, xt; logic [13:0] d, md; logic signed [17:0] xo, yo;
    pulse(20000, -20000, lat, d, xo, yo);
    model(20000, -20000, xs, ys, md);
    xv = xo;
    tests++; if (d[0] !== 1'b1) begin fails++; $display("FAIL dg_d0 got %0b want 1", d[0]); end
    tests++; if (xv < 28280 || xv > 28288) begin fails++; $display("FAIL dg_mag got %0d want 28284+-4", xv); end
    tests++; if (d !== md) begin fails++; $display("FAIL dg_d got %h want %h", d, md); end
    tests++; if (yo !== 18'(ys)) begin fails++; $display("FAIL dg_y got %0d want %0d", yo, ys); end
    // Replay the emitted directions as rotations on the original vector.
    x = 20000; y = -20000;
    for (int k = 0; k < 14; k++) begin
      if (d[k]) begin xt = x - (y >>> k); y = y + (x >>> k); end
      else      begin xt = x + (y >>> k); y = y - (x >>> k); end
      x = xt;
    end
    tests++; if (y < -4 || y > 4) begin fails++; $display("FAIL dg_replay got %0d want |y|<=4", y); end
  endtask

  task automatic test_back_to_back();
    bit vin[23]; int xin[23], yin[23];
    int xs, ys, j; logic [13:0] md, ed; logic signed [17:0] ex, ey; bit have, ev;
    have = 0; ed = '0; ex = '0; ey = '0;
    for (int i = 0; i < 23; i++) begin
      vin[i] = (i < 16) || (i >= 19);
      xin[i] = int'($urandom_range(60000));
      yin[i] = int'($urandom_range(120000)) - 60000;
    end
    for (int c = 0; c < 28; c++) begin
      j = c - 4;
      ev = (j >= 0 && j < 23) ? vin[j] : 1'b0;
      tests++;
      if (valid_o !== ev) begin fails++; $display("FAIL b2b_valid cyc %0d got %0b want %0b", c, valid_o, ev); end
      if (ev) begin
        model(xin[j], yin[j], xs, ys, md);
        ed = md; ex = exp_x(xs); ey = 18'(ys); have = 1;
      end
      if (have) begin
        tests++; if (d_o !== ed) begin fails++; $display("FAIL b2b_d cyc %0d got %h want %h", c, d_o, ed); end
        tests++; if (X_o !== ex) begin fails++; $display("FAIL b2b_x cyc %0d got %0d want %0d", c, X_o, ex); end
        tests++; if (Y_o !== ey) begin fails++; $display("FAIL b2b_y cyc %0d got %0d want %0d", c, Y_o, ey); end
      end
      if (c < 23 && vin[c]) begin
        valid_i = 1; X_i = 18'(xin[c]); Y_i = 18'(yin[c]);
      end else begin
        valid_i = 0; X_i = 18'sd54321; Y_i = -18'sd12345;
      end
      step();
    end
  endtask

  task automatic test_round();
    int lat, xs, ys, fx, fy; bit found; longint p;
    logic [13:0] d, md; logic signed [17:0] xo, yo, tr, want;
    found = 0; fx = 0; fy = 0;
    for (int x = 4900; x <= 5050 && !found; x++)
      for (int y = 0; y <= 400 && !found; y++) begin
        model(x, y, xs, ys, md);
        p = longint'(xs) * 64'sd9949;
        if ((p & 64'sd16383) == 64'sd8192) begin found = 1; fx = x; fy = y; end
      end
    tests++;
    if (!found) begin fails++; $display("FAIL rnd_search no input with P[13:0]=2000"); return; end
    model(fx, fy, xs, ys, md);
    tr = scale(xs, 1'b0);
`ifdef VEC_ANGLE_ROUND_EN
    want = tr + 18'sd1;
`else
    want = tr;
`endif
    pulse(fx, fy, lat, d, xo, yo);
    tests++; if (xo !== want) begin fails++; $display("FAIL rnd_x got %0d want %0d (trunc %0d)", xo, want, tr); end
    tests++; if (d !== md) begin fails++; $display("FAIL rnd_d got %h want %h", d, md); end
    tests++; if (yo !== 18'(ys)) begin fails++; $display("FAIL rnd_y got %0d want %0d", yo, ys); end
  endtask

  initial begin
    #1;
    test_reset();
    test_mag_3_4();
    test_zero_y();
    test_diag();
    test_back_to_back();
    test_round();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
